// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, round/pack FSM states, format limits, flag indices.
package fpu_pkg;

    typedef enum logic [1:0] {
        RmRne = 2'b00,
        RmRz  = 2'b01,
        RmRup = 2'b10,
        RmRdn = 2'b11
    } rm_e;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } state_e;

    // Exponent bias and all-ones (inf/NaN) biased exponent, 12 bits wide to absorb carries
    localparam logic [11:0] DExpBias = 12'd1023;
    localparam logic [11:0] SExpBias = 12'd127;
    localparam logic [11:0] DExpMax  = 12'd2047;
    localparam logic [11:0] SExpMax  = 12'd255;

    // Bit positions inside the 4-bit flags bundle {overflow, underflow, inexact, invalid}
    localparam int unsigned FlagOvf = 3;
    localparam int unsigned FlagUnf = 2;
    localparam int unsigned FlagNx  = 1;
    localparam int unsigned FlagNv  = 0;

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment decision from sign, lsb, guard/round/sticky and rounding mode.
module fp_round_inc
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       st,
    input  logic [1:0] rm,
    output logic       inc
);

    // Decide whether to add one ulp
    always_comb begin
        inc = 1'b0;
        unique case (rm_e'(rm))
            RmRne:   inc = g & (r | st | lsb);
            RmRz:    inc = 1'b0;
            RmRup:   inc = ~sign & (g | r | st);
            RmRdn:   inc = sign & (g | r | st);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// FP adder back end: iterative normalization, rounding and binary64/binary32 packing.
module fp_round_pack
    import fpu_pkg::*;
#(
    parameter int unsigned EW = 11,
    parameter int unsigned FW = 57
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          ss,
    input  logic [EW-1:0] es,
    input  logic [FW-1:0] fs,
    input  logic          db,
    input  logic [1:0]    RM,
    input  logic          special,
    input  logic [63:0]   special_val,
    input  logic          special_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   result,
    output logic [3:0]    flags
);

    localparam logic [EW:0]   ExpOne = {{EW{1'b0}}, 1'b1};
    localparam logic [FW-1:0] DUlp   = FW'(64'h8);
    localparam logic [FW-1:0] SUlp   = FW'(64'h1_0000_0000);

    state_e        state_q, state_d;
    logic          ss_q, db_q;
    logic [1:0]    rm_q;
    logic [EW:0]   es_q;
    logic [FW-1:0] fs_q;
    logic [63:0]   result_q;
    logic [3:0]    flags_q;

    logic          norm_shl;
    logic          rnd_lsb, rnd_g, rnd_r, rnd_st, rnd_inc, inexact;
    logic [FW-1:0] rnd_sum, rnd_sig;
    logic [EW:0]   rnd_exp;
    logic          is_norm, ovf, use_inf;
    logic [63:0]   round_res;
    logic [3:0]    round_flags;
    logic          unused_bits;

    // Another left shift is needed while the integer bit is clear and the exponent allows it
    assign norm_shl = ~fs_q[56] & ~fs_q[55] & (fs_q != '0) & (es_q > ExpOne);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = special ? StDone : StNorm;
            StNorm:  if (!norm_shl) state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Rounding position: binary32 keeps g/r at bits 2:1 and folds bits 31:3 into sticky
    always_comb begin
        rnd_lsb = db_q ? fs_q[3] : fs_q[32];
        rnd_g   = fs_q[2];
        rnd_r   = fs_q[1];
        rnd_st  = fs_q[0] | (~db_q & (|fs_q[31:3]));
        inexact = rnd_g | rnd_r | rnd_st;
    end

    fp_round_inc u_round_inc (
        .sign (ss_q),
        .lsb  (rnd_lsb),
        .g    (rnd_g),
        .r    (rnd_r),
        .st   (rnd_st),
        .rm   (rm_q),
        .inc  (rnd_inc)
    );

    // Apply increment, renormalize on carry, detect overflow and pack
    always_comb begin
        rnd_sum = fs_q + (rnd_inc ? (db_q ? DUlp : SUlp) : '0);
        if (rnd_sum[56]) begin
            rnd_sig = rnd_sum >> 1;
            rnd_exp = es_q + ExpOne;
        end else begin
            rnd_sig = rnd_sum;
            rnd_exp = es_q;
        end
        // A subnormal reaching bit55 is normal with exponent 1 (es_q was forced to 1)
        is_norm = rnd_sig[55];
        ovf     = is_norm & (rnd_exp >= (db_q ? DExpMax : SExpMax));
        use_inf = (rm_e'(rm_q) == RmRne) | ((rm_e'(rm_q) == RmRup) & ~ss_q) |
                  ((rm_e'(rm_q) == RmRdn) & ss_q);
        if (db_q) begin
            if (ovf) begin
                round_res = use_inf ? {ss_q, 11'h7ff, 52'h0} : {ss_q, 11'h7fe, {52{1'b1}}};
            end else begin
                round_res = {ss_q, (is_norm ? rnd_exp[10:0] : 11'h0), rnd_sig[54:3]};
            end
        end else begin
            if (ovf) begin
                round_res = use_inf ? {32'h0, ss_q, 8'hff, 23'h0}
                                    : {32'h0, ss_q, 8'hfe, {23{1'b1}}};
            end else begin
                round_res = {32'h0, ss_q, (is_norm ? rnd_exp[7:0] : 8'h0), rnd_sig[54:32]};
            end
        end
        round_flags          = '0;
        round_flags[FlagOvf] = ovf;
        round_flags[FlagUnf] = ~is_norm & inexact;
        round_flags[FlagNx]  = inexact | ovf;
        round_flags[FlagNv]  = 1'b0;
    end

    assign unused_bits = ^{rnd_sig[56], rnd_sig[2:0]};

    // Datapath: capture in IDLE, one normalization step per NORM cycle, latch result in ROUND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q     <= 1'b0;
            db_q     <= 1'b0;
            rm_q     <= 2'b00;
            es_q     <= '0;
            fs_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ss_q <= ss;
                        es_q <= {1'b0, es};
                        fs_q <= fs;
                        db_q <= db;
                        rm_q <= RM;
                        if (special) begin
                            result_q <= db ? special_val : {32'h0, special_val[31:0]};
                            flags_q  <= {3'b000, special_inv};
                        end
                    end
                end
                StNorm: begin
                    if (fs_q[56]) begin
                        fs_q <= {1'b0, fs_q[56:2], fs_q[1] | fs_q[0]};
                        es_q <= es_q + ExpOne;
                    end else if (norm_shl) begin
                        fs_q <= fs_q << 1;
                        es_q <= es_q - ExpOne;
                    end else if (!fs_q[55] && fs_q != '0) begin
                        es_q <= ExpOne;
                    end
                end
                StRound: begin
                    result_q <= round_res;
                    flags_q  <= round_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed cases plus randomized bundles against a value-level model.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ss = 1'b0;
    logic [10:0] es = '0;
    logic [56:0] fs = '0;
    logic        db = 1'b1;
    logic [1:0]  RM = 2'b00;
    logic        special = 1'b0;
    logic [63:0] special_val = '0;
    logic        special_inv = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    fp_round_pack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ss          (ss),
        .es          (es),
        .fs          (fs),
        .db          (db),
        .RM          (RM),
        .special     (special),
        .special_val (special_val),
        .special_inv (special_inv),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Value-level model: locate leading one, pick the final exponent directly, round in ulps.
    // Latency is edges after the accept edge; a special bundle is visible right after accept.
    function automatic void model(input logic s, input logic [10:0] e, input logic [56:0] f,
                                  input logic d, input logic [1:0] rm, input logic sp,
                                  input logic [63:0] spv, input logic spi,
                                  output logic [63:0] res, output logic [3:0] fl,
                                  output int lat);
        longint unsigned a, q, frac, ef;
        int p, k, en, fb, sh, emax, ei;
        logic lsb, g, r, st, inc, inex, normal, use_inf;
        if (sp) begin
            res = d ? spv : {32'h0, spv[31:0]};
            fl  = {3'b000, spi};
            lat = 0;
            return;
        end
        fb   = d ? 52 : 23;
        sh   = d ? 3 : 32;
        emax = d ? 2047 : 255;
        ei   = int'(e);
        if (f == '0) begin
            res = d ? {s, 63'h0} : {32'h0, s, 31'h0};
            fl  = 4'b0000;
            lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 57; i++) if (f[i]) p = i;
        k = 0;
        if (p == 56) begin
            a  = (64'(f) >> 1) | 64'(f[0]);
            en = ei + 1;
        end else begin
            k  = (55 - p < ei - 1) ? 55 - p : ei - 1;
            if (k < 0) k = 0;
            a  = 64'(f) << k;
            en = ei - k;
        end
        lat  = 2 + k;
        lsb  = a[sh];
        g    = a[2];
        r    = a[1];
        st   = a[0] | (!d && (a[31:3] != 0));
        inex = g | r | st;
        case (rm)
            2'b00:   inc = g & (r | st | lsb);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !s && inex;
            default: inc = s && inex;
        endcase
        q = (a >> sh) + 64'(inc);
        if (q >= (64'd1 << (fb + 1))) begin
            q  = q >> 1;
            en = en + 1;
        end
        normal = (q >= (64'd1 << fb));
        if (normal && en >= emax) begin
            use_inf = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
            ef      = use_inf ? 64'(emax) : 64'(emax - 1);
            frac    = use_inf ? 64'd0 : ((64'd1 << fb) - 1);
            fl      = 4'b1010;
        end else begin
            ef   = normal ? 64'(en) : 64'd0;
            frac = q & ((64'd1 << fb) - 1);
            fl   = {1'b0, !normal && inex, inex, 1'b0};
        end
        res = (64'(s) << (d ? 63 : 31)) | (ef << fb) | frac;
    endfunction

    // Apply one bundle, wait (bounded) for the result, compare with the model.
    // hold > 0 keeps out_ready low that many cycles and checks the output is stable.
    task automatic run(input string tag, input logic s, input logic [10:0] e,
                       input logic [56:0] f, input logic d, input logic [1:0] rm,
                       input logic sp, input logic [63:0] spv, input logic spi, input int hold,
                       output logic [63:0] o_res, output logic [3:0] o_fl, output int o_lat);
        logic [63:0] er;
        logic [3:0]  ef;
        int          el;
        bit          busy_bad, unstable;
        model(s, e, f, d, rm, sp, spv, spi, er, ef, el);
        @(negedge clk);
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        ss = s; es = e; fs = f; db = d; RM = rm;
        special = sp; special_val = spv; special_inv = spi;
        out_ready = (hold == 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // scramble inputs so only the captured copy can be used
        ss = 1'($urandom); es = 11'($urandom); fs = {25'($urandom), $urandom};
        db = 1'($urandom); RM = 2'($urandom); special = 1'($urandom);
        special_val = {$urandom, $urandom}; special_inv = 1'($urandom);
        o_lat = 0;
        busy_bad = 0;
        while (!out_valid && o_lat < 100) begin
            if (in_ready) busy_bad = 1;
            @(posedge clk);
            #1;
            o_lat++;
        end
        if (in_ready) busy_bad = 1;
        o_res = result;
        o_fl  = flags;
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " latency"}, 64'(o_lat), 64'(el));
        chk({tag, " result"}, o_res, er);
        chk({tag, " flags"}, 64'(o_fl), 64'(ef));
        chk({tag, " in_ready busy"}, 64'(busy_bad), 64'd0);
        if (hold > 0) begin
            unstable = 0;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!out_valid || result !== o_res || flags !== o_fl) unstable = 1;
            end
            chk({tag, " hold stable"}, 64'(unstable), 64'd0);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, " released"}, 64'(out_valid), 64'd0);
        n_vec++;
    endtask

    initial begin
        logic [63:0] r64, raw;
        logic [3:0]  f4;
        int          lat;
        logic [56:0] rf;
        logic [10:0] re;
        logic        rd;
        int          emx;

        // Reset state
        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3.0 + 3.0: carry-out right shift
        run("add3", 1'b0, 11'h400, 57'h180_0000_0000_0000, 1'b1, 2'b00, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("add3 const result", r64, 64'h4018_0000_0000_0000);
        chk("add3 const latency", 64'(lat), 64'd2);

        // Three left shifts
        run("lnorm", 1'b0, 11'h400, 57'h10_0000_0000_0000, 1'b1, 2'b00, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("lnorm const result", r64, 64'h3fd0_0000_0000_0000);
        chk("lnorm const latency", 64'(lat), 64'd5);

        // Tie: RNE keeps even, toward +inf increments
        run("tie rne", 1'b0, 11'h3ff, 57'h80_0000_0000_0004, 1'b1, 2'b00, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("tie rne const", r64, 64'h3ff0_0000_0000_0000);
        chk("tie rne flags", 64'(f4), 64'h2);
        run("tie rup", 1'b0, 11'h3ff, 57'h80_0000_0000_0004, 1'b1, 2'b10, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("tie rup const", r64, 64'h3ff0_0000_0000_0001);

        // Overflow
        run("ovf rne", 1'b0, 11'h7fe, 57'h100_0000_0000_0004, 1'b1, 2'b00, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("ovf rne const", r64, 64'h7ff0_0000_0000_0000);
        chk("ovf rne flags", 64'(f4), 64'ha);
        run("ovf rz", 1'b0, 11'h7fe, 57'h100_0000_0000_0004, 1'b1, 2'b01, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("ovf rz const", r64, 64'h7fef_ffff_ffff_ffff);
        run("ovf rdn neg", 1'b1, 11'h7fe, 57'h100_0000_0000_0004, 1'b1, 2'b11, 1'b0, '0, 1'b0,
            0, r64, f4, lat);
        run("ovf rdn pos", 1'b0, 11'h7fe, 57'h100_0000_0000_0004, 1'b1, 2'b11, 1'b0, '0, 1'b0,
            0, r64, f4, lat);

        // Subnormal with back-pressure
        run("subn", 1'b0, 11'h001, 57'h40_0000_0000_0000, 1'b1, 2'b00, 1'b0, '0, 1'b0, 4,
            r64, f4, lat);
        chk("subn const", r64, 64'h0008_0000_0000_0000);
        chk("subn flags", 64'(f4), 64'h0);

        // Signed zero, binary32 6.0, special bypass in both formats
        run("zero neg", 1'b1, 11'h400, 57'h0, 1'b1, 2'b00, 1'b0, '0, 1'b0, 0, r64, f4, lat);
        run("sp32", 1'b0, 11'h080, 57'h180_0000_0000_0000, 1'b0, 2'b00, 1'b0, '0, 1'b0, 0,
            r64, f4, lat);
        chk("sp32 const", r64, 64'h0000_0000_40c0_0000);
        run("special32", 1'b0, 11'h0, 57'h0, 1'b0, 2'b00, 1'b1, 64'hdead_beef_7fc0_0001, 1'b1,
            0, r64, f4, lat);
        chk("special32 const", r64, 64'h0000_0000_7fc0_0001);
        run("special64", 1'b1, 11'h0, 57'h0, 1'b1, 2'b00, 1'b1, 64'hfff0_0000_0000_0000, 1'b0,
            0, r64, f4, lat);

        // Reset mid-NORM drops the bundle
        @(negedge clk);
        ss = 1'b0; es = 11'h400; fs = 57'h10_0000_0000_0000; db = 1'b1; RM = 2'b00;
        special = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run("post reset add3", 1'b0, 11'h400, 57'h180_0000_0000_0000, 1'b1, 2'b00, 1'b0, '0,
            1'b0, 0, r64, f4, lat);
        chk("post reset const", r64, 64'h4018_0000_0000_0000);

        // Randomized bundles, biased toward exponent extremes
        for (int i = 0; i < 80; i++) begin
            raw = {$urandom, $urandom};
            rf  = 57'(raw) >> $urandom_range(0, 56);
            if ($urandom_range(0, 5) == 0) rf[56] = 1'b1;
            rd  = 1'($urandom);
            emx = rd ? 2046 : 254;
            case ($urandom_range(0, 3))
                0:       re = 11'($urandom_range(1, 3));
                1:       re = 11'($urandom_range(emx - 2, emx));
                default: re = 11'($urandom_range(1, emx));
            endcase
            run("rand", 1'($urandom), re, rf, rd, 2'($urandom), ($urandom_range(0, 15) == 0),
                {$urandom, $urandom}, 1'($urandom), 0, r64, f4, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
